// File: rtl/num_sink_pkg.sv
// Shared types and constants for the num_gen / num_sink endpoint pair.
// Holds the sink FSM state encoding, the default destination and payload
// width, and the LFSR seed/taps used for pseudo-random flow control.
package num_pkg;

    // Sink packet-tracking states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BODY    = 2'd1,
        DISCARD = 2'd2
    } sink_state_e;

    // Default endpoint destination and meaningful payload bits
    localparam logic [3:0] DEF_MY_DEST = 4'h2;
    localparam int         DEF_DATA_W  = 8;

    // 8-bit Fibonacci LFSR, polynomial x^8 + x^6 + x^5 + x^4 + 1.
    // The taps mask selects bits 7,5,4,3 (stages 8,6,5,4).
    localparam int         LFSR_W    = 8;
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/num_sink_if.sv
// AXI-Stream channel bundle between a num_gen master and a num_sink slave.
// Signal names follow the AXI-Stream T* naming so an instance named AXIS_S
// reads as AXIS_S.TVALID, AXIS_S.TREADY, ...
interface num_sink_if #(
    parameter int TDATAW = 32,
    parameter int TDESTW = 4,
    parameter int TIDW   = 2
);
    logic              TVALID;
    logic              TREADY;
    logic [TDATAW-1:0] TDATA;
    logic              TLAST;
    logic [TIDW-1:0]   TID;
    logic [TDESTW-1:0] TDEST;

    modport master (
        output TVALID, TDATA, TLAST, TID, TDEST,
        input  TREADY
    );

    modport slave (
        input  TVALID, TDATA, TLAST, TID, TDEST,
        output TREADY
    );
endinterface

// File: rtl/num_sink_bp_lfsr.sv
// Pseudo-random backpressure source for num_sink: an 8-bit Fibonacci LFSR
// that advances every cycle and yields a ~50% duty "ready allowed" bit.
// Only instantiated when NUM_SINK_BP_EN is defined.
module num_sink_bp_lfsr
    import num_pkg::*;
(
    input  logic clk,
    input  logic rst,
    output logic bp_ok
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    // Shift left, feeding the XOR of the tapped bits into bit 0
    always_comb begin
        lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
    end

    // LFSR register, reseeded on reset so traffic patterns are repeatable
    always_ff @(posedge clk) begin
        if (rst) lfsr_q <= LFSR_SEED;
        else     lfsr_q <= lfsr_d;
    end

    assign bp_ok = lfsr_q[LFSR_W-1];

endmodule

// File: rtl/num_sink.sv
// num_sink: AXI-Stream slave terminating num_gen traffic at a NoC endpoint.
// Checks destination, payload range and packet length per packet and keeps
// saturating packet/beat/error counters plus a wrapping sum of good payloads.
// Build option: define NUM_SINK_BP_EN to gate TREADY with pseudo-random
// backpressure from num_sink_bp_lfsr; otherwise TREADY is high whenever the
// block is not in reset or clear.
module num_sink
    import num_pkg::*;
#(
    parameter int              TDATAW    = 32,
    parameter int              TDESTW    = 4,
    parameter int              TIDW      = 2,
    parameter int              DATA_W    = DEF_DATA_W,
    parameter logic [TDESTW-1:0] MY_DEST = TDESTW'(DEF_MY_DEST),
    parameter int              MAX_BEATS = 16,
    parameter int              CNTW      = 16,
    parameter int              SUMW      = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CLEAR,
    num_sink_if.slave         AXIS_S,
    output logic [CNTW-1:0]   PKT_CNT,
    output logic [CNTW-1:0]   BEAT_CNT,
    output logic [CNTW-1:0]   ERR_CNT,
    output logic [SUMW-1:0]   DATA_SUM,
    output logic [DATA_W-1:0] LAST_DATA,
    output logic [TIDW-1:0]   LAST_TID,
    output logic              ERR_DEST,
    output logic              ERR_RANGE,
    output logic              ERR_LEN,
    output logic              BUSY
);

    // Wide enough to hold MAX_BEATS itself
    localparam int BCW = $clog2(MAX_BEATS + 1);

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------------
    logic bp_ok;

`ifdef NUM_SINK_BP_EN
    num_sink_bp_lfsr u_bp_lfsr (
        .clk   (CLK),
        .rst   (RST),
        .bp_ok (bp_ok)
    );
`else
    assign bp_ok = 1'b1;
`endif

    // Ready never looks at TVALID; dropping it during CLEAR means no beat
    // can land in the same cycle the statistics are being zeroed.
    logic tready;
    logic beat;

    assign tready        = ~RST & ~CLEAR & bp_ok;
    assign AXIS_S.TREADY = tready;
    assign beat          = AXIS_S.TVALID & tready;

    // ------------------------------------------------------------------
    // Per-beat checks
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] payload;
    logic              dest_err;
    logic              range_err;

    assign payload  = AXIS_S.TDATA[DATA_W-1:0];
    assign dest_err = (AXIS_S.TDEST != MY_DEST);

    generate
        if (TDATAW > DATA_W) begin : g_range
            assign range_err = |AXIS_S.TDATA[TDATAW-1:DATA_W];
        end else begin : g_no_range
            assign range_err = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    sink_state_e       state_q,     state_d;
    logic [BCW-1:0]    pkt_beats_q, pkt_beats_d;
    logic              pkt_bad_q,   pkt_bad_d;
    logic [SUMW-1:0]   acc_q,       acc_d;

    logic [CNTW-1:0]   pkt_cnt_q,   pkt_cnt_d;
    logic [CNTW-1:0]   beat_cnt_q,  beat_cnt_d;
    logic [CNTW-1:0]   err_cnt_q,   err_cnt_d;
    logic [SUMW-1:0]   data_sum_q,  data_sum_d;
    logic [DATA_W-1:0] last_data_q, last_data_d;
    logic [TIDW-1:0]   last_tid_q,  last_tid_d;
    logic              err_dest_q,  err_dest_d;
    logic              err_range_q, err_range_d;
    logic              err_len_q,   err_len_d;
    logic              busy_q,      busy_d;

    // Position of the current beat inside its packet (1-based). Once in
    // DISCARD the length has already been flagged, so no further hits.
    logic [BCW-1:0] pos;
    logic           len_hit;
    logic           pkt_bad_now;

    assign pos         = pkt_beats_q + BCW'(1);
    assign len_hit     = beat & ~AXIS_S.TLAST & (state_q != DISCARD) &
                         (pos == BCW'(MAX_BEATS));
    assign pkt_bad_now = pkt_bad_q | dest_err | range_err | len_hit;

    // Next-state, packet tracking and statistics update
    always_comb begin
        state_d     = state_q;
        pkt_beats_d = pkt_beats_q;
        pkt_bad_d   = pkt_bad_q;
        acc_d       = acc_q;
        pkt_cnt_d   = pkt_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        err_cnt_d   = err_cnt_q;
        data_sum_d  = data_sum_q;
        last_data_d = last_data_q;
        last_tid_d  = last_tid_q;
        err_dest_d  = err_dest_q;
        err_range_d = err_range_q;
        err_len_d   = err_len_q;

        if (CLEAR) begin
            // Statistics only; an in-flight packet keeps its state and sum
            pkt_cnt_d   = '0;
            beat_cnt_d  = '0;
            err_cnt_d   = '0;
            data_sum_d  = '0;
            err_dest_d  = 1'b0;
            err_range_d = 1'b0;
            err_len_d   = 1'b0;
        end else if (beat) begin
            beat_cnt_d  = sat_inc(beat_cnt_q);
            last_data_d = payload;
            last_tid_d  = AXIS_S.TID;
            err_dest_d  = err_dest_q  | dest_err;
            err_range_d = err_range_q | range_err;
            err_len_d   = err_len_q   | len_hit;

            if (AXIS_S.TLAST) begin
                if (pkt_bad_now) begin
                    err_cnt_d = sat_inc(err_cnt_q);
                end else begin
                    pkt_cnt_d  = sat_inc(pkt_cnt_q);
                    data_sum_d = data_sum_q + acc_q + SUMW'(payload);
                end
                state_d     = IDLE;
                pkt_beats_d = '0;
                pkt_bad_d   = 1'b0;
                acc_d       = '0;
            end else begin
                pkt_bad_d = pkt_bad_now;
                if (state_q != DISCARD) begin
                    pkt_beats_d = pos;
                    acc_d       = acc_q + SUMW'(payload);
                end
                if (len_hit)              state_d = DISCARD;
                else if (state_q == IDLE) state_d = BODY;
            end
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset drops any packet in flight
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            pkt_beats_q <= '0;
            pkt_bad_q   <= 1'b0;
            acc_q       <= '0;
            pkt_cnt_q   <= '0;
            beat_cnt_q  <= '0;
            err_cnt_q   <= '0;
            data_sum_q  <= '0;
            last_data_q <= '0;
            last_tid_q  <= '0;
            err_dest_q  <= 1'b0;
            err_range_q <= 1'b0;
            err_len_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pkt_beats_q <= pkt_beats_d;
            pkt_bad_q   <= pkt_bad_d;
            acc_q       <= acc_d;
            pkt_cnt_q   <= pkt_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            err_cnt_q   <= err_cnt_d;
            data_sum_q  <= data_sum_d;
            last_data_q <= last_data_d;
            last_tid_q  <= last_tid_d;
            err_dest_q  <= err_dest_d;
            err_range_q <= err_range_d;
            err_len_q   <= err_len_d;
            busy_q      <= busy_d;
        end
    end

    assign PKT_CNT   = pkt_cnt_q;
    assign BEAT_CNT  = beat_cnt_q;
    assign ERR_CNT   = err_cnt_q;
    assign DATA_SUM  = data_sum_q;
    assign LAST_DATA = last_data_q;
    assign LAST_TID  = last_tid_q;
    assign ERR_DEST  = err_dest_q;
    assign ERR_RANGE = err_range_q;
    assign ERR_LEN   = err_len_q;
    assign BUSY      = busy_q;

endmodule

// File: tb/tb_num_sink.sv
// Bench for num_sink (default build: no backpressure).
// A packet-level model (queue of payloads + bad flag) predicts every output;
// a negedge process compares, and directed tests pin hand-computed values.
module tb_num_sink;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_i, clr_i;
    logic [15:0] PKT_CNT, BEAT_CNT, ERR_CNT;
    logic [31:0] DATA_SUM;
    logic [7:0]  LAST_DATA;
    logic [1:0]  LAST_TID;
    logic ERR_DEST, ERR_RANGE, ERR_LEN, BUSY;

    num_sink_if #(.TDATAW(32), .TDESTW(4), .TIDW(2)) axis ();

    num_sink dut (
        .CLK(clk), .RST(rst_i), .CLEAR(clr_i), .AXIS_S(axis),
        .PKT_CNT(PKT_CNT), .BEAT_CNT(BEAT_CNT), .ERR_CNT(ERR_CNT),
        .DATA_SUM(DATA_SUM), .LAST_DATA(LAST_DATA), .LAST_TID(LAST_TID),
        .ERR_DEST(ERR_DEST), .ERR_RANGE(ERR_RANGE), .ERR_LEN(ERR_LEN), .BUSY(BUSY)
    );

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- packet-level model ----------------
    int unsigned exp_pkt, exp_beat, exp_err;
    bit [31:0]   exp_sum;
    bit [7:0]    exp_last_data;
    bit [1:0]    exp_last_tid;
    bit          exp_ed, exp_er, exp_el, exp_busy;
    int unsigned pkt_q[$];
    bit          pkt_bad;

    function automatic int unsigned sat16(input int unsigned v);
        return (v < 65535) ? v + 1 : v;
    endfunction

    task automatic model_step();
        bit [31:0] s;
        if (rst_i) begin
            exp_pkt = 0; exp_beat = 0; exp_err = 0; exp_sum = 0;
            exp_last_data = 0; exp_last_tid = 0;
            exp_ed = 0; exp_er = 0; exp_el = 0; exp_busy = 0;
            pkt_q.delete(); pkt_bad = 0;
        end else if (clr_i) begin
            exp_pkt = 0; exp_beat = 0; exp_err = 0; exp_sum = 0;
            exp_ed = 0; exp_er = 0; exp_el = 0;
        end else if (axis.TVALID) begin
            exp_beat      = sat16(exp_beat);
            exp_last_data = axis.TDATA[7:0];
            exp_last_tid  = axis.TID;
            pkt_q.push_back(axis.TDATA[7:0]);
            if (axis.TDEST != 4'd2)   begin exp_ed = 1; pkt_bad = 1; end
            if (axis.TDATA > 32'd255) begin exp_er = 1; pkt_bad = 1; end
            if (!axis.TLAST && pkt_q.size() == 16) begin exp_el = 1; pkt_bad = 1; end
            if (axis.TLAST) begin
                if (pkt_bad) exp_err = sat16(exp_err);
                else begin
                    exp_pkt = sat16(exp_pkt);
                    s = 0;
                    foreach (pkt_q[i]) s += pkt_q[i];
                    exp_sum += s;
                end
                pkt_q.delete(); pkt_bad = 0;
            end
            exp_busy = (pkt_q.size() != 0);
        end
    endtask

    // Every-cycle comparison, half a cycle after the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("tready",    {31'd0, axis.TREADY}, {31'd0, !rst_i && !clr_i});
            chk("pkt_cnt",   {16'd0, PKT_CNT},   exp_pkt);
            chk("beat_cnt",  {16'd0, BEAT_CNT},  exp_beat);
            chk("err_cnt",   {16'd0, ERR_CNT},   exp_err);
            chk("data_sum",  DATA_SUM,           exp_sum);
            chk("last_data", {24'd0, LAST_DATA}, {24'd0, exp_last_data});
            chk("last_tid",  {30'd0, LAST_TID},  {30'd0, exp_last_tid});
            chk("err_dest",  {31'd0, ERR_DEST},  {31'd0, exp_ed});
            chk("err_range", {31'd0, ERR_RANGE}, {31'd0, exp_er});
            chk("err_len",   {31'd0, ERR_LEN},   {31'd0, exp_el});
            chk("busy",      {31'd0, BUSY},      {31'd0, exp_busy});
        end
    end

    // ---------------- stimulus ----------------
    task automatic cycle(input bit v, input logic [31:0] d, input bit l,
                         input logic [1:0] id, input logic [3:0] de,
                         input bit r, input bit c);
        axis.TVALID = v; axis.TDATA = d; axis.TLAST = l;
        axis.TID = id; axis.TDEST = de; rst_i = r; clr_i = c;
        @(posedge clk);
        model_step();
        #2;
    endtask

    task automatic beat(input logic [31:0] d, input bit l, input logic [3:0] de);
        cycle(1'b1, d, l, d[1:0], de, 1'b0, 1'b0);
    endtask

    task automatic idle();
        cycle(1'b0, 32'd0, 1'b0, 2'd0, 4'd2, 1'b0, 1'b0);
    endtask

    task automatic clear();
        cycle(1'b0, 32'd0, 1'b0, 2'd0, 4'd2, 1'b0, 1'b1);
    endtask

    initial begin
        cycle(1'b0, 32'd0, 1'b0, 2'd0, 4'd2, 1'b1, 1'b0);
        chk_en = 1'b1;
        cycle(1'b0, 32'd0, 1'b0, 2'd0, 4'd2, 1'b1, 1'b0);
        chk("rst_pkt_cnt", {16'd0, PKT_CNT}, 32'd0);
        chk("rst_busy",    {31'd0, BUSY},    32'd0);
        idle();

        // 1: three single-beat packets
        beat(32'd5, 1, 4'd2); beat(32'd7, 1, 4'd2); beat(32'd9, 1, 4'd2);
        chk("t1_pkt",  {16'd0, PKT_CNT},  32'd3);
        chk("t1_beat", {16'd0, BEAT_CNT}, 32'd3);
        chk("t1_sum",  DATA_SUM,          32'd21);
        chk("t1_err",  {16'd0, ERR_CNT},  32'd0);
        chk("t1_last", {24'd0, LAST_DATA}, 32'd9);

        // 2: four-beat packet with a bubble
        clear();
        beat(32'd1, 0, 4'd2); chk("t2_busy1", {31'd0, BUSY}, 32'd1);
        beat(32'd2, 0, 4'd2); chk("t2_busy2", {31'd0, BUSY}, 32'd1);
        idle();               chk("t2_busyg", {31'd0, BUSY}, 32'd1);
        beat(32'd3, 0, 4'd2); chk("t2_busy3", {31'd0, BUSY}, 32'd1);
        chk("t2_sum_mid", DATA_SUM, 32'd0);
        beat(32'd4, 1, 4'd2); chk("t2_busy4", {31'd0, BUSY}, 32'd0);
        chk("t2_pkt", {16'd0, PKT_CNT}, 32'd1);
        chk("t2_sum", DATA_SUM, 32'd10);

        // 3: wrong destination
        clear();
        beat(32'd8, 1, 4'd3);
        chk("t3_edest", {31'd0, ERR_DEST}, 32'd1);
        chk("t3_err",   {16'd0, ERR_CNT},  32'd1);
        chk("t3_pkt",   {16'd0, PKT_CNT},  32'd0);
        chk("t3_sum",   DATA_SUM,          32'd0);

        // 3b: bad beat mid-packet counts the packet once
        clear();
        beat(32'd1, 0, 4'd2); beat(32'd2, 0, 4'd3); beat(32'd3, 1, 4'd2);
        chk("t3b_err", {16'd0, ERR_CNT}, 32'd1);
        chk("t3b_sum", DATA_SUM,         32'd0);

        // 4: payload out of range, then a good packet
        clear();
        beat(32'h0000_0100, 1, 4'd2);
        chk("t4_erange", {31'd0, ERR_RANGE}, 32'd1);
        chk("t4_err",    {16'd0, ERR_CNT},   32'd1);
        beat(32'd6, 1, 4'd2);
        chk("t4_sum", DATA_SUM, 32'd6);

        // 5: 20-beat packet overflows at beat 16
        clear();
        for (int i = 1; i <= 20; i++) begin
            beat(i, (i == 20), 4'd2);
            if (i == 15) chk("t5_elen15", {31'd0, ERR_LEN}, 32'd0);
            if (i == 16) chk("t5_elen16", {31'd0, ERR_LEN}, 32'd1);
        end
        chk("t5_err",  {16'd0, ERR_CNT},  32'd1);
        chk("t5_beat", {16'd0, BEAT_CNT}, 32'd20);
        chk("t5_pkt",  {16'd0, PKT_CNT},  32'd0);

        // 5b: exactly MAX_BEATS with TLAST is legal
        clear();
        for (int i = 1; i <= 16; i++) beat(32'd1, (i == 16), 4'd2);
        chk("t5b_pkt",  {16'd0, PKT_CNT}, 32'd1);
        chk("t5b_sum",  DATA_SUM,         32'd16);
        chk("t5b_elen", {31'd0, ERR_LEN}, 32'd0);

        // CLEAR mid-packet keeps the accumulator
        clear();
        beat(32'd3, 0, 4'd2);
        cycle(1'b1, 32'd100, 1'b0, 2'd0, 4'd2, 1'b0, 1'b1);
        beat(32'd4, 1, 4'd2);
        chk("tc_sum",  DATA_SUM,          32'd7);
        chk("tc_beat", {16'd0, BEAT_CNT}, 32'd1);

        // 6: reset mid-packet, then CLEAR with TVALID held
        beat(32'd5, 0, 4'd2);
        cycle(1'b1, 32'd11, 1'b0, 2'd1, 4'd2, 1'b1, 1'b0);
        chk("t6_rst_beat", {16'd0, BEAT_CNT}, 32'd0);
        chk("t6_rst_busy", {31'd0, BUSY},     32'd0);
        cycle(1'b1, 32'd11, 1'b1, 2'd1, 4'd2, 1'b0, 1'b1);
        chk("t6_clr_beat", {16'd0, BEAT_CNT}, 32'd0);
        chk("t6_clr_data", {24'd0, LAST_DATA}, 32'd0);
        beat(32'd9, 1, 4'd2);
        chk("t6_pkt", {16'd0, PKT_CNT}, 32'd1);
        chk("t6_sum", DATA_SUM,         32'd9);
        idle();

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
